mem_resp_stage: RTL
===================

MEM_RESP_STAGE -- requirements
Module: mem_resp_stage

Interface
REQ-001 Parameter DW, default 32, datapath width; legal values are 32 and 64.
REQ-002 Parameter MAXC, default 2, maximum number of cancelled data responses still owed by memory; legal range 1..7.
REQ-003 Parameter DESTW, default 5, register-file destination index width.
REQ-004 clk  in  1  clock; all state updates on the rising edge.
REQ-005 rstn  in  1  reset, synchronous, active-low.
REQ-006 flush  in  1  exception/ertn flush; kills the op held in this stage.
REQ-007 in_valid  in  1  upstream stage offers an op.
REQ-008 in_allowin  out  1  this stage accepts an op this cycle.
REQ-009 in_pc  in  32  op PC.
REQ-010 in_dest / in_gr_we  in  DESTW / 1  destination register and write enable.
REQ-011 in_req_sent  in  1  upstream issued a data-SRAM read for this op.
REQ-012 in_ld_type  in  3  load type: 0 none, 1 ld.b, 2 ld.bu, 3 ld.h, 4 ld.hu, 5 ld.w, 6 ld.wu, 7 ld.d.
REQ-013 in_addr_lo  in  3  low bits of the load address.
REQ-014 in_alu_result  in  DW  non-load result.
REQ-015 data_ok / rdata  in  1 / DW  data-SRAM response strobe and read data.
REQ-016 out_valid  out  1  downstream offer; out_allowin  in  1  downstream accepts.
REQ-017 out_pc / out_dest / out_gr_we / out_result  out  32 / DESTW / 1 / DW  writeback fields.
REQ-018 fwd_dest  out  DESTW  held dest, forced to 0 unless valid && gr_we.
REQ-019 fwd_result  out  DW  bypass value; fwd_busy  out  1  held op is a load whose data has not yet arrived.
REQ-020 proto_err  out  1  sticky protocol-error flag.

Function
REQ-021 State: valid, the latched op fields, a waiting flag, hold_vld with hold_data[DW-1:0], and cancel_cnt[2:0].
REQ-022 Waiting is set when the latched op has in_req_sent=1; it clears when that op's response is taken.
REQ-023 ready_go = !waiting || hold_vld || (data_ok && cancel_cnt==0).
REQ-024 in_allowin = !valid || (ready_go && out_allowin), combinational.
REQ-025 out_valid = valid && ready_go && !flush.
REQ-026 An op is latched when in_valid && in_allowin && !flush, and is visible the next cycle; zero-bubble throughput when no waits occur.
REQ-027 A data_ok arriving while cancel_cnt>0 is a stale response: discard it and decrement cancel_cnt.
REQ-028 A data_ok arriving while cancel_cnt==0 and waiting belongs to the held op.
REQ-029 If the held op is also leaving this cycle, the data goes straight to the result path.
REQ-030 Otherwise, store the data in hold_data and set hold_vld.
REQ-031 hold_vld clears when the op leaves or is flushed.
REQ-032 A data_ok with cancel_cnt==0 and no waiting op (or with hold_vld already set) sets proto_err; the data is dropped.
REQ-033 Load data = hold_vld ? hold_data : rdata, shifted right by in_addr_lo*8.
REQ-034 Byte/half/word loads sign- or zero-extend to DW.
REQ-035 Misaligned offsets yield a zero result: half with addr_lo[0]=1; word with addr_lo[1:0]!=0; dword with addr_lo!=0.
REQ-036 For DW=32, addr_lo[2] is ignored, and types 6 and 7 yield 0.
REQ-037 out_result = (ld_type!=0) ? load data : alu_result; fwd_result = out_result.
REQ-038 On flush with valid && waiting && !hold_vld, and no owned data_ok in the same cycle, increment cancel_cnt.
REQ-039 A stale decrement and an increment in the same cycle leave cancel_cnt unchanged.
REQ-040 On flush, an owned data_ok in the same cycle is discarded with no increment.
REQ-041 cancel_cnt saturates at MAXC; an increment attempted at MAXC sets proto_err.
REQ-042 Flush clears valid, waiting and hold_vld, and blocks latching in that cycle; cancel_cnt persists across flush.
REQ-043 While cancel_cnt>0, a new op may be latched; its wait is satisfied only after the stale responses drain.

Reset
REQ-044 When rstn=0 at a clock edge: valid, waiting, hold_vld, cancel_cnt and proto_err become 0, and latched fields become 0.
REQ-045 Consequences of reset: out_valid=0, fwd_dest=0, fwd_busy=0, and in_allowin=1 in the following cycle.
REQ-046 Reset mid-wait discards all pending state; any later data_ok then sets proto_err (memory is expected to be reset together with this block).

Verification
REQ-047 Back-to-back ALU ops, out_allowin=1: pc 0x1c000000/04/08 emerge on consecutive cycles with one-cycle latency.
REQ-048 ld.b, addr_lo=3, rdata=0x80FF_1234, data_ok 2 cycles late: fwd_busy=1 for 2 cycles, then out_result=0xFFFF_FF80.
REQ-049 ld.hu, addr_lo=2, data_ok while out_allowin=0 for 3 cycles: hold_vld=1, then out_result=0x0000_80FF once allowin rises.
REQ-050 Flush while a load waits, then new load issued, then two data_ok (0xAAAA_AAAA, 0x5555_5555): first discarded, second delivered, cancel_cnt ends 0.
REQ-051 Unsolicited data_ok with empty stage: proto_err=1 and stays 1 until rstn=0.
REQ-052 DW=64, ld.d, addr_lo=0, rdata=0x0123_4567_89AB_CDEF -> out_result equal; the same op with addr_lo=4 -> out_result 0.

Source files
------------

// File: rtl/mem_resp_stage.sv
// -----------------------------------------------------------------------------
// mem_resp_stage
//
// Memory-response pipeline stage. Holds one op between the memory-issue stage
// and writeback, waits for the data-SRAM read response of a load, formats the
// load data (shift, sign/zero extension, misalignment squash) and offers the
// result downstream with a valid/allowin handshake. Loads killed by a flush
// while their read is still in flight are tracked in a cancel counter so the
// stale responses that arrive later are recognised and discarded.
//
// Parameters
//   DW     datapath width (32 or 64)
//   MAXC   max number of cancelled responses still owed by memory (1..7)
//   DESTW  register-file destination index width
//
// Ports
//   clk, rstn          clock, synchronous active-low reset
//   flush              kills the op held in this stage
//   in_valid/in_allowin  upstream handshake
//   in_pc, in_dest, in_gr_we, in_req_sent, in_ld_type, in_addr_lo,
//   in_alu_result      op fields offered by upstream
//   data_ok, rdata     data-SRAM response strobe and read data
//   out_valid/out_allowin  downstream handshake
//   out_pc, out_dest, out_gr_we, out_result  writeback fields
//   fwd_dest, fwd_result, fwd_busy  bypass information for the decode stage
//   proto_err          sticky flag: unexpected response or cancel overflow
// -----------------------------------------------------------------------------
module mem_resp_stage #(
  parameter int DW    = 32,
  parameter int MAXC  = 2,
  parameter int DESTW = 5
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_allowin,
  input  logic [31:0]      in_pc,
  input  logic [DESTW-1:0] in_dest,
  input  logic             in_gr_we,
  input  logic             in_req_sent,
  input  logic [2:0]       in_ld_type,
  input  logic [2:0]       in_addr_lo,
  input  logic [DW-1:0]    in_alu_result,
  input  logic             data_ok,
  input  logic [DW-1:0]    rdata,
  output logic             out_valid,
  input  logic             out_allowin,
  output logic [31:0]      out_pc,
  output logic [DESTW-1:0] out_dest,
  output logic             out_gr_we,
  output logic [DW-1:0]    out_result,
  output logic [DESTW-1:0] fwd_dest,
  output logic [DW-1:0]    fwd_result,
  output logic             fwd_busy,
  output logic             proto_err
);

  localparam logic [2:0] MAXC_C = 3'(MAXC);

  // Extract the loaded value from a raw memory word. Everything is done on a
  // 64-bit intermediate so the extension code is identical for both widths;
  // with DW=32 the top address bit is ignored and doubleword/unsigned-word
  // loads do not exist, so they return zero.
  function automatic logic [DW-1:0] load_extract(
    input logic [DW-1:0] raw,
    input logic [2:0]    ty,
    input logic [2:0]    lo
  );
    logic [63:0] raw64;
    logic [63:0] sh64;
    logic [63:0] res64;
    logic [2:0]  off;
    raw64 = 64'(raw);
    off   = (DW == 32) ? {1'b0, lo[1:0]} : lo;
    sh64  = raw64 >> {off, 3'b000};
    res64 = 64'd0;
    case (ty)
      3'd1: res64 = {{56{sh64[7]}}, sh64[7:0]};
      3'd2: res64 = {56'd0, sh64[7:0]};
      3'd3: begin
        if (off[0] == 1'b0) res64 = {{48{sh64[15]}}, sh64[15:0]};
        else                res64 = 64'd0;
      end
      3'd4: begin
        if (off[0] == 1'b0) res64 = {48'd0, sh64[15:0]};
        else                res64 = 64'd0;
      end
      3'd5: begin
        if (off[1:0] == 2'b00) res64 = {{32{sh64[31]}}, sh64[31:0]};
        else                   res64 = 64'd0;
      end
      3'd6: begin
        if ((DW != 32) && (off[1:0] == 2'b00)) res64 = {32'd0, sh64[31:0]};
        else                                   res64 = 64'd0;
      end
      3'd7: begin
        if ((DW != 32) && (off == 3'd0)) res64 = sh64;
        else                             res64 = 64'd0;
      end
      default: res64 = 64'd0;
    endcase
    return res64[DW-1:0];
  endfunction

  // Architectural state
  logic             valid_r;
  logic [31:0]      pc_r;
  logic [DESTW-1:0] dest_r;
  logic             gr_we_r;
  logic [2:0]       ld_type_r;
  logic [2:0]       addr_lo_r;
  logic [DW-1:0]    alu_r;
  logic             waiting_r;
  logic             hold_vld_r;
  logic [DW-1:0]    hold_data_r;
  logic [2:0]       cancel_cnt_r;
  logic             proto_err_r;

  // Next-state values
  logic             valid_nxt_s;
  logic [31:0]      pc_nxt_s;
  logic [DESTW-1:0] dest_nxt_s;
  logic             gr_we_nxt_s;
  logic [2:0]       ld_type_nxt_s;
  logic [2:0]       addr_lo_nxt_s;
  logic [DW-1:0]    alu_nxt_s;
  logic             waiting_nxt_s;
  logic             hold_vld_nxt_s;
  logic [DW-1:0]    hold_data_nxt_s;
  logic [2:0]       cancel_cnt_nxt_s;
  logic             proto_err_nxt_s;

  // Combinational control
  logic             ready_go_s;
  logic             latch_s;
  logic             leave_s;
  logic             stale_s;
  logic             owned_s;
  logic             spurious_s;
  logic             inc_s;
  logic             overflow_s;
  logic [DW-1:0]    load_raw_s;
  logic [DW-1:0]    result_s;

  // Response classification and handshake. waiting_r is cleared as soon as the
  // response is captured in the hold register, so waiting_r alone tells whether
  // the held op still owns the next non-stale response.
  always_comb begin
    stale_s    = data_ok && (cancel_cnt_r != 3'd0);
    owned_s    = data_ok && (cancel_cnt_r == 3'd0) && waiting_r;
    spurious_s = data_ok && (cancel_cnt_r == 3'd0) && !waiting_r;
    ready_go_s = !waiting_r || hold_vld_r || (data_ok && (cancel_cnt_r == 3'd0));
    in_allowin = !valid_r || (ready_go_s && out_allowin);
    out_valid  = valid_r && ready_go_s && !flush;
    leave_s    = out_valid && out_allowin;
    latch_s    = in_valid && in_allowin && !flush;
    // A flushed load whose read is still outstanding leaves a response owed.
    inc_s      = flush && valid_r && waiting_r && !hold_vld_r && !owned_s;
    overflow_s = inc_s && !stale_s && (cancel_cnt_r == MAXC_C);
  end

  // Result path: captured data wins over the live bus once it has been held.
  always_comb begin
    load_raw_s = hold_vld_r ? hold_data_r : rdata;
    if (ld_type_r != 3'd0) result_s = load_extract(load_raw_s, ld_type_r, addr_lo_r);
    else                   result_s = alu_r;
  end

  // Output field mapping and bypass information.
  always_comb begin
    out_pc     = pc_r;
    out_dest   = dest_r;
    out_gr_we  = gr_we_r;
    out_result = result_s;
    fwd_result = result_s;
    fwd_busy   = valid_r && !ready_go_s;
    proto_err  = proto_err_r;
    if (valid_r && gr_we_r) fwd_dest = dest_r;
    else                    fwd_dest = '0;
  end

  // Next-state logic for the op slot, hold register, cancel counter and error.
  always_comb begin
    valid_nxt_s      = valid_r;
    pc_nxt_s         = pc_r;
    dest_nxt_s       = dest_r;
    gr_we_nxt_s      = gr_we_r;
    ld_type_nxt_s    = ld_type_r;
    addr_lo_nxt_s    = addr_lo_r;
    alu_nxt_s        = alu_r;
    waiting_nxt_s    = waiting_r;
    hold_vld_nxt_s   = hold_vld_r;
    hold_data_nxt_s  = hold_data_r;
    cancel_cnt_nxt_s = cancel_cnt_r;
    proto_err_nxt_s  = proto_err_r | spurious_s | overflow_s;

    if (flush) begin
      // Flush kills the held op and any captured data; an owned response
      // arriving in this same cycle is simply dropped.
      valid_nxt_s    = 1'b0;
      waiting_nxt_s  = 1'b0;
      hold_vld_nxt_s = 1'b0;
    end else if (latch_s) begin
      // Latching implies the previous op (if any) is leaving this cycle.
      valid_nxt_s    = 1'b1;
      pc_nxt_s       = in_pc;
      dest_nxt_s     = in_dest;
      gr_we_nxt_s    = in_gr_we;
      ld_type_nxt_s  = in_ld_type;
      addr_lo_nxt_s  = in_addr_lo;
      alu_nxt_s      = in_alu_result;
      waiting_nxt_s  = in_req_sent;
      hold_vld_nxt_s = 1'b0;
    end else if (leave_s) begin
      valid_nxt_s    = 1'b0;
      waiting_nxt_s  = 1'b0;
      hold_vld_nxt_s = 1'b0;
    end else if (owned_s) begin
      // Downstream stalled while the data arrived: park it.
      hold_vld_nxt_s  = 1'b1;
      hold_data_nxt_s = rdata;
      waiting_nxt_s   = 1'b0;
    end else begin
      valid_nxt_s = valid_r;
    end

    // Simultaneous stale discard and new cancellation cancel each other out.
    case ({inc_s, stale_s})
      2'b10: begin
        if (cancel_cnt_r == MAXC_C) cancel_cnt_nxt_s = cancel_cnt_r;
        else                        cancel_cnt_nxt_s = cancel_cnt_r + 3'd1;
      end
      2'b01:   cancel_cnt_nxt_s = cancel_cnt_r - 3'd1;
      default: cancel_cnt_nxt_s = cancel_cnt_r;
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      valid_r      <= 1'b0;
      pc_r         <= 32'd0;
      dest_r       <= '0;
      gr_we_r      <= 1'b0;
      ld_type_r    <= 3'd0;
      addr_lo_r    <= 3'd0;
      alu_r        <= '0;
      waiting_r    <= 1'b0;
      hold_vld_r   <= 1'b0;
      hold_data_r  <= '0;
      cancel_cnt_r <= 3'd0;
      proto_err_r  <= 1'b0;
    end else begin
      valid_r      <= valid_nxt_s;
      pc_r         <= pc_nxt_s;
      dest_r       <= dest_nxt_s;
      gr_we_r      <= gr_we_nxt_s;
      ld_type_r    <= ld_type_nxt_s;
      addr_lo_r    <= addr_lo_nxt_s;
      alu_r        <= alu_nxt_s;
      waiting_r    <= waiting_nxt_s;
      hold_vld_r   <= hold_vld_nxt_s;
      hold_data_r  <= hold_data_nxt_s;
      cancel_cnt_r <= cancel_cnt_nxt_s;
      proto_err_r  <= proto_err_nxt_s;
    end
  end

endmodule
